// File: rtl/boot_memory.sv
// Boot memory: clears the whole array after reset, then accepts a program
// image from a loader starting at LOAD_BASE, then releases the CPU and
// serves as its single-port, read-first, one-cycle-latency RAM.
module boot_memory #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LOAD_BASE  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] out,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  cpu_rst_n,
    output logic                  ld_ovf
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] clr_ptr_q;
    logic [ADDR_WIDTH-1:0] ld_ptr_q;
    logic [DATA_WIDTH-1:0] out_q;
    logic                  ld_ready_q;
    logic                  cpu_rst_n_q;
    logic                  ld_ovf_q;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  xfer;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    // Select the single array write port owner according to the phase.
    always_comb begin
        xfer    = (state_q == LOAD) && ld_valid;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        unique case (state_q)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clr_ptr_q;
                wr_data = '0;
            end
            LOAD: begin
                wr_en   = xfer;
                wr_addr = ld_ptr_q;
                wr_data = ld_data;
            end
            RUN: begin
                wr_en   = we;
                wr_addr = addr;
                wr_data = data;
            end
            default: ;
        endcase
        // No array writes while reset is held; the first clear write lands
        // on the first rising edge after release.
        wr_en = wr_en && rst_n;
    end

    // Array storage: plain registers, contents defined only by the clear pass.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Phase sequencer with registered handshake, CPU hold, overflow flag and read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            clr_ptr_q   <= '0;
            ld_ptr_q    <= ADDR_WIDTH'(LOAD_BASE);
            out_q       <= '0;
            ld_ready_q  <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            ld_ovf_q    <= 1'b0;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    out_q     <= '0;
                    clr_ptr_q <= clr_ptr_q + 1'b1;
                    if (clr_ptr_q == '1) begin
                        state_q    <= LOAD;
                        ld_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    out_q <= '0;
                    if (xfer) begin
                        if (ld_last || (ld_ptr_q == '1)) begin
                            state_q     <= RUN;
                            ld_ready_q  <= 1'b0;
                            cpu_rst_n_q <= 1'b1;
                            if (!ld_last) begin
                                ld_ovf_q <= 1'b1;
                            end
                        end
                        // Pointer stops at the top address instead of wrapping.
                        if (ld_ptr_q != '1) begin
                            ld_ptr_q <= ld_ptr_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Nonblocking array write makes this read return the old word.
                    out_q <= mem_q[addr];
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    assign out       = out_q;
    assign ld_ready  = ld_ready_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign ld_ovf    = ld_ovf_q;

endmodule

// File: tb/tb_boot_memory.sv
// Directed self-checking bench for boot_memory (default geometry: 64 x 16, base 8).
module tb_boot_memory;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [5:0]  addr;
    logic [15:0] data;
    logic [15:0] out;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        cpu_rst_n;
    logic        ld_ovf;

    int n_checks;
    int n_fail;

    boot_memory #(
        .ADDR_WIDTH(6),
        .DATA_WIDTH(16),
        .LOAD_BASE (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .addr     (addr),
        .data     (data),
        .out      (out),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .cpu_rst_n(cpu_rst_n),
        .ld_ovf   (ld_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a read address for one cycle and return what the CPU port shows.
    task automatic rd(input logic [5:0] a, output logic [15:0] v);
        we   = 1'b0;
        addr = a;
        tick();
        v = out;
    endtask

    // Count cycles until ld_ready rises; also report whether the CPU
    // stayed held with out at zero during that time.
    task automatic wait_ready(output int n, output bit clean);
        n     = 0;
        clean = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (cpu_rst_n !== 1'b0 || out !== 16'h0000) clean = 1'b0;
            if (ld_ready === 1'b1) break;
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        bit clean;
        rst_n = 1'b0;
        #3;
        n_checks += 4;
        if (out !== 16'h0000) begin n_fail++; $display("FAIL reset_out got=%h exp=0000", out); end
        if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ld_ready got=%b exp=0", ld_ready); end
        if (cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_rst_n got=%b exp=0", cpu_rst_n); end
        if (ld_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ld_ovf got=%b exp=0", ld_ovf); end
        tick();
        tick();
        rst_n = 1'b1;
        wait_ready(n, clean);
        n_checks += 2;
        if (n !== 64) begin n_fail++; $display("FAIL clear_cycles got=%0d exp=64", n); end
        if (clean !== 1'b1) begin n_fail++; $display("FAIL clear_hold got=%b exp=1", clean); end
    endtask

    task automatic test_load_three();
        logic [15:0] v;
        logic [5:0]  ra [6];
        logic [15:0] re [6];
        ra = '{6'd8, 6'd9, 6'd10, 6'd0, 6'd11, 6'd20};
        re = '{16'h1234, 16'h0005, 16'hF000, 16'h0000, 16'h0000, 16'h0000};
        // CPU write attempted during LOAD must be dropped.
        we = 1'b1; addr = 6'd20; data = 16'hDEAD;
        tick();
        we = 1'b0;
        ld_valid = 1'b1; ld_data = 16'h1234; ld_last = 1'b0;
        tick();
        ld_data = 16'h0005;
        tick();
        n_checks += 2;
        if (cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL load3_early_run got=%b exp=0", cpu_rst_n); end
        if (out !== 16'h0000) begin n_fail++; $display("FAIL load3_out_held got=%h exp=0000", out); end
        ld_data = 16'hF000; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        n_checks += 3;
        if (cpu_rst_n !== 1'b1) begin n_fail++; $display("FAIL load3_cpu_rst_n got=%b exp=1", cpu_rst_n); end
        if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL load3_ld_ready got=%b exp=0", ld_ready); end
        if (ld_ovf !== 1'b0) begin n_fail++; $display("FAIL load3_ld_ovf got=%b exp=0", ld_ovf); end
        // Loader traffic in RUN must not write anything.
        ld_valid = 1'b1; ld_data = 16'h7777;
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rd(ra[i], v);
            n_checks++;
            if (v !== re[i]) begin
                n_fail++;
                $display("FAIL load3_read addr=%0d got=%h exp=%h", ra[i], v, re[i]);
            end
        end
    endtask

    task automatic test_run_write();
        logic [15:0] v;
        we = 1'b1; addr = 6'd5; data = 16'hABCD;
        tick();
        we = 1'b0;
        n_checks++;
        if (out !== 16'h0000) begin n_fail++; $display("FAIL run_read_first got=%h exp=0000", out); end
        rd(6'd5, v);
        n_checks++;
        if (v !== 16'hABCD) begin n_fail++; $display("FAIL run_write_visible got=%h exp=abcd", v); end
        // Back-to-back writes to two addresses, then read both.
        we = 1'b1; addr = 6'd6; data = 16'h1357;
        tick();
        addr = 6'd7; data = 16'h2468;
        tick();
        rd(6'd6, v);
        n_checks++;
        if (v !== 16'h1357) begin n_fail++; $display("FAIL b2b_addr6 got=%h exp=1357", v); end
        rd(6'd7, v);
        n_checks++;
        if (v !== 16'h2468) begin n_fail++; $display("FAIL b2b_addr7 got=%h exp=2468", v); end
        addr = 6'd5;
        tick();
    endtask

    task automatic test_reset_in_run();
        logic [15:0] v;
        int n;
        bit clean;
        // out currently shows 0xABCD from address 5.
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL rst_run_cpu_rst_n got=%b exp=0", cpu_rst_n); end
        if (out !== 16'h0000) begin n_fail++; $display("FAIL rst_run_out got=%h exp=0000", out); end
        tick();
        rst_n = 1'b1;
        wait_ready(n, clean);
        n_checks++;
        if (n !== 64) begin n_fail++; $display("FAIL rst_run_clear_cycles got=%0d exp=64", n); end
        ld_valid = 1'b1; ld_data = 16'h00AA; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        rd(6'd5, v);
        n_checks++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL rst_run_addr5_zeroed got=%h exp=0000", v); end
        rd(6'd8, v);
        n_checks++;
        if (v !== 16'h00AA) begin n_fail++; $display("FAIL rst_run_addr8 got=%h exp=00aa", v); end
    endtask

    task automatic test_gaps();
        logic [15:0] v;
        logic [5:0]  ra [4];
        logic [15:0] re [4];
        int n;
        bit clean;
        ra = '{6'd8, 6'd9, 6'd10, 6'd11};
        re = '{16'h1111, 16'h2222, 16'h0000, 16'h0000};
        pulse_reset();
        wait_ready(n, clean);
        ld_valid = 1'b1; ld_data = 16'h1111; ld_last = 1'b0;
        tick();
        ld_valid = 1'b0; ld_data = 16'hBADD; ld_last = 1'b1;
        tick();
        tick();
        n_checks++;
        if (ld_ready !== 1'b1 || cpu_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps_still_loading ld_ready=%b cpu_rst_n=%b exp=1/0", ld_ready, cpu_rst_n);
        end
        ld_valid = 1'b1; ld_data = 16'h2222; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        n_checks++;
        if (cpu_rst_n !== 1'b1) begin n_fail++; $display("FAIL gaps_run got=%b exp=1", cpu_rst_n); end
        for (int i = 0; i < 4; i++) begin
            rd(ra[i], v);
            n_checks++;
            if (v !== re[i]) begin
                n_fail++;
                $display("FAIL gaps_read addr=%0d got=%h exp=%h", ra[i], v, re[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] v;
        logic [5:0]  ra [5];
        logic [15:0] re [5];
        int n;
        bit clean;
        bit ready_ok;
        ra = '{6'd8, 6'd62, 6'd63, 6'd7, 6'd0};
        re = '{16'h0100, 16'h0136, 16'h0137, 16'h0000, 16'h0000};
        pulse_reset();
        wait_ready(n, clean);
        ready_ok = 1'b1;
        ld_last  = 1'b0;
        for (int i = 0; i < 56; i++) begin
            if (ld_ready !== 1'b1) ready_ok = 1'b0;
            ld_valid = 1'b1;
            ld_data  = 16'h0100 + 16'(i);
            tick();
        end
        ld_valid = 1'b0;
        n_checks += 4;
        if (ready_ok !== 1'b1) begin n_fail++; $display("FAIL ovf_ready_during_load got=%b exp=1", ready_ok); end
        if (cpu_rst_n !== 1'b1) begin n_fail++; $display("FAIL ovf_cpu_rst_n got=%b exp=1", cpu_rst_n); end
        if (ld_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", ld_ovf); end
        if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ld_ready got=%b exp=0", ld_ready); end
        ld_valid = 1'b1; ld_data = 16'hEEEE;
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd(ra[i], v);
            n_checks++;
            if (v !== re[i]) begin
                n_fail++;
                $display("FAIL ovf_read addr=%0d got=%h exp=%h", ra[i], v, re[i]);
            end
        end
        n_checks++;
        if (ld_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", ld_ovf); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ld_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_reset_clear got=%b exp=0", ld_ovf); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        we       = 1'b0;
        addr     = '0;
        data     = '0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
        test_reset();
        test_load_three();
        test_run_write();
        test_reset_in_run();
        test_gaps();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/boot_memory.md
BOOT_MEMORY -- requirements
Module: boot_memory

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, word-address width of the array (2^ADDR_WIDTH words).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, word width.
REQ-003 SHALL have parameter LOAD_BASE, default 8, first address written by the loader (CPU program start).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port we  input  1  CPU write enable.
REQ-007 SHALL have port addr  input  ADDR_WIDTH  CPU word address.
REQ-008 SHALL have port data  input  DATA_WIDTH  CPU write data.
REQ-009 SHALL have port out  output  DATA_WIDTH  registered read data to CPU (CPU's mem_in).
REQ-010 SHALL have port ld_valid  input  1  loader word valid.
REQ-011 SHALL have port ld_data  input  DATA_WIDTH  loader word.
REQ-012 SHALL have port ld_last  input  1  marks final loader word; qualified by ld_valid.
REQ-013 SHALL have port ld_ready  output  1  loader may transfer this cycle.
REQ-014 SHALL have port cpu_rst_n  output  1  active-low hold for the CPU; 1 only in RUN.
REQ-015 SHALL have port ld_ovf  output  1  sticky: load ended at top address without ld_last.

Function
REQ-016 SHALL implement FSM states CLEAR, LOAD, RUN; single state register.
REQ-017 CLEAR: write 0 to address clr_ptr each cycle, clr_ptr from 0 upward; after writing address 2^ADDR_WIDTH-1 go to LOAD (exactly 2^ADDR_WIDTH cycles in CLEAR).
REQ-018 LOAD: ld_ready=1; transfer occurs when ld_valid&&ld_ready; word written to ld_ptr, ld_ptr starts at LOAD_BASE and increments by 1 per transfer.
REQ-019 LOAD: ld_ready=0 in CLEAR and RUN; ld_valid outside LOAD SHALL be ignored, no write.
REQ-020 LOAD exit: transfer with ld_last=1 -> RUN next cycle; transfer at address 2^ADDR_WIDTH-1 with ld_last=0 -> RUN next cycle and ld_ovf<=1; ld_ptr never wraps.
REQ-021 LOAD with no transfers SHALL wait indefinitely; ld_valid low cycles add no writes.
REQ-022 RUN: terminal until reset; cpu_rst_n=1 (registered, asserted the cycle state becomes RUN).
REQ-023 RUN write: we=1 writes data to mem[addr] at the rising edge.
REQ-024 RUN read: out <= mem[addr] every cycle, one-cycle latency, read-first (same-cycle write to same address returns old value; new value visible next access).
REQ-025 out SHALL be held at 0 in CLEAR and LOAD; we/addr/data ignored outside RUN.
REQ-026 Address arithmetic SHALL be ADDR_WIDTH-bit unsigned; clr_ptr/ld_ptr sized so terminal-address compare is exact.
REQ-027 Array SHALL be plain registers (no reset on array); contents defined only via CLEAR.

Reset
REQ-028 rst_n low SHALL immediately set state=CLEAR, clr_ptr=0, ld_ptr=LOAD_BASE, out=0, ld_ready=0, cpu_rst_n=0, ld_ovf=0.
REQ-029 rst_n low mid-LOAD or mid-RUN SHALL abort; after release the full CLEAR then LOAD sequence repeats; previously loaded words are zeroed.
REQ-030 First CLEAR write SHALL occur on the first rising edge with rst_n high.

Verification
REQ-031 Reset release, no loader activity -> ld_ready rises after exactly 64 cycles; cpu_rst_n stays 0; out stays 0.
REQ-032 Load 3 words 0x1234, 0x0005, 0xF000 (last on third) -> mem[8..10] hold them, RUN next cycle, cpu_rst_n=1, ld_ovf=0; read addr 9 -> out=0x0005 one cycle later; addr 0 -> 0x0000.
REQ-033 Load with gaps (ld_valid toggling 1,0,0,1 with last) -> exactly 2 writes at 8 and 9; no write during low cycles.
REQ-034 Load 56 words without ld_last -> word 56 written at 63, RUN entered, ld_ovf=1.
REQ-035 RUN: we=1 addr=5 data=0xABCD, next cycle read addr 5 -> first cycle out=old 0x0000, then 0xABCD; CPU writes during LOAD ignored.
REQ-036 rst_n pulse low during RUN -> cpu_rst_n=0 and out=0 asynchronously; after reload of 1 word, previously written addr 5 reads 0x0000.
